// File: rtl/clock_pkg.sv
// clock_pkg: digit-scan constants and types shared by the display scan and the digit demux.
package clock_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int SEL_W = 2;
  localparam int BCD_W = 4;
  typedef logic [SEL_W-1:0] digit_idx_t;
  function automatic logic [BCD_W-1:0] nibble(input logic [NUM_DIGITS*BCD_W-1:0] v, input digit_idx_t i);
    return v[i*BCD_W +: BCD_W];
  endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: enabled prescale counter with terminal-count pulse and look-ahead next value.
module tick_gen #(
  parameter int PRESCALE = 100000,
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] next,
  output logic             tc
);
  assign tc = en && count == CNT_W'(PRESCALE - 1);
  assign next = !en ? count : tc ? '0 : count + 1'b1;
  always_ff @(posedge clk) begin
    if (!rst_n) count <= '0;
    else count <= next;
  end
endmodule

// File: rtl/display_scan.sv
// display_scan: four-digit multiplex scan with per-slot blanking and frame-latched display data.
module display_scan
  import clock_pkg::*;
#(
  parameter int PRESCALE = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W = 17
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [NUM_DIGITS*BCD_W-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  output logic [SEL_W-1:0]            digit_sel,
  output logic [BCD_W-1:0]            digit_bcd,
  output logic                        dp_out,
  output logic                        blank,
  output logic                        frame_tick
);
  if (PRESCALE < 2 || BLANK_CYCLES >= PRESCALE || (64'd1 << CNT_W) < 64'(PRESCALE)) begin : g_bad_params
    $error("display_scan: illegal PRESCALE/BLANK_CYCLES/CNT_W");
  end
  localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK_CYCLES);
  logic [CNT_W-1:0] count, next;
  logic tc, wrap, load, loaded;
  digit_idx_t sel_n;
  logic [NUM_DIGITS*BCD_W-1:0] shadow, shadow_n;
  logic [NUM_DIGITS-1:0] dp_sh, dp_sh_n;
  tick_gen #(.PRESCALE(PRESCALE), .CNT_W(CNT_W)) u_tick (
    .clk(clk), .rst_n(rst_n), .en(en), .count(count), .next(next), .tc(tc)
  );
  // The first enabled cycle after reset fills the shadow so the display is never stuck at zero for a frame.
  always_comb begin
    wrap = tc && digit_sel == digit_idx_t'(NUM_DIGITS - 1);
    load = en && (!loaded || wrap);
    sel_n = tc ? digit_sel + 1'b1 : digit_sel;
    shadow_n = load ? digits_in : shadow;
    dp_sh_n = load ? dp_in : dp_sh;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loaded <= 1'b0;
      shadow <= '0;
      dp_sh <= '0;
      digit_sel <= '0;
      digit_bcd <= '0;
      dp_out <= 1'b0;
      blank <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      loaded <= loaded | en;
      shadow <= shadow_n;
      dp_sh <= dp_sh_n;
      digit_sel <= sel_n;
      digit_bcd <= nibble(shadow_n, sel_n);
      dp_out <= dp_sh_n[sel_n];
      blank <= !en || next < BLANK_C;
      frame_tick <= wrap;
    end
  end
endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: randomized and directed checks of display_scan against a slot/frame arithmetic model.
module tb_display_scan;
  localparam int P = 8;
  localparam int B = 2;
  localparam int F = 4 * P;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0] dp_in = '0;
  logic [1:0] digit_sel;
  logic [3:0] digit_bcd;
  logic dp_out, blank, frame_tick;
  logic [8:0] obs;
  int n_checks = 0;
  int n_fail = 0;
  int e;
  bit loaded, en_ok, ft;
  logic [15:0] sh_d;
  logic [3:0] sh_dp;
  assign obs = {digit_sel, digit_bcd, dp_out, blank, frame_tick};
  always #5 clk = ~clk;
  display_scan #(.PRESCALE(P), .BLANK_CYCLES(B), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .digits_in(digits_in), .dp_in(dp_in),
    .digit_sel(digit_sel), .digit_bcd(digit_bcd), .dp_out(dp_out),
    .blank(blank), .frame_tick(frame_tick)
  );
  // e counts enabled cycles since reset; slot, count and frame position all derive from it.
  function automatic logic [8:0] expected();
    int s;
    s = (e / P) % 4;
    return {2'(s), sh_d[s*4 +: 4], sh_dp[s], !en_ok || (e % P) < B, ft};
  endfunction
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      e = 0; loaded = 0; en_ok = 0; ft = 0; sh_d = '0; sh_dp = '0;
    end else begin
      ft = 0;
      en_ok = en;
      if (en) begin
        if (!loaded || (e + 1) % F == 0) begin
          sh_d = digits_in;
          sh_dp = dp_in;
        end
        loaded = 1;
        e++;
        ft = (e % F == 0);
      end
    end
    #1;
  endtask
  task automatic run_to(input int r);
    for (int i = 0; i < 4 * F && e % F != r; i++) tick();
  endtask
  task automatic test_reset();
    rst_n = 0; en = 1; digits_in = 16'h1234; dp_in = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs !== 9'b00_0000_0_1_0) begin
        n_fail++;
        $display("FAIL reset cyc %0d: got %b want %b", i, obs, 9'b00_0000_0_1_0);
      end
    end
  endtask
  task automatic test_scan_order();
    int ticks = 0;
    rst_n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i < F) ticks += int'(frame_tick);
      n_checks++;
      if (obs !== expected()) begin
        n_fail++;
        $display("FAIL scan cyc %0d: got %h want %h", i, obs, expected());
      end
    end
    n_checks++;
    if (ticks !== 1) begin
      n_fail++;
      $display("FAIL frame_tick_count: got %0d want 1", ticks);
    end
  endtask
  task automatic test_blanking();
    int high = 0;
    run_to(0);
    for (int i = 0; i < 2 * P; i++) begin
      high += int'(blank);
      n_checks++;
      if (blank !== ((e % P) < B)) begin
        n_fail++;
        $display("FAIL blank cnt %0d: got %b want %b", e % P, blank, (e % P) < B);
      end
      tick();
    end
    n_checks++;
    if (high !== 2 * B) begin
      n_fail++;
      $display("FAIL blank_total: got %0d want %0d", high, 2 * B);
    end
  endtask
  task automatic test_tearing();
    run_to(P);
    digits_in = 16'h5678; dp_in = 4'b0101;
    for (int i = 0; i < 2 * F; i++) begin
      tick();
      n_checks++;
      if (obs !== expected()) begin
        n_fail++;
        $display("FAIL tearing cyc %0d: got %h want %h", i, obs, expected());
      end
    end
  endtask
  task automatic test_enable();
    int n = 0;
    run_to(2 * P + 5);
    en = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (obs !== expected() || blank !== 1'b1 || digit_sel !== 2'd2) begin
        n_fail++;
        $display("FAIL enable_hold cyc %0d: got %h want %h", i, obs, expected());
      end
    end
    en = 1;
    while (digit_sel == 2'd2 && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (n !== 3 || digit_sel !== 2'd3) begin
      n_fail++;
      $display("FAIL enable_resume: got %0d cycles sel %0d want 3 cycles sel 3", n, digit_sel);
    end
  endtask
  task automatic test_mid_reset();
    run_to(3 * P + 6);
    rst_n = 0;
    tick();
    rst_n = 1;
    n_checks++;
    if (obs !== 9'b00_0000_0_1_0) begin
      n_fail++;
      $display("FAIL mid_reset: got %b want %b", obs, 9'b00_0000_0_1_0);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      n_checks++;
      if (obs !== expected()) begin
        n_fail++;
        $display("FAIL restart cyc %0d: got %h want %h", i, obs, expected());
      end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) begin
        digits_in = 16'($urandom);
        dp_in = 4'($urandom);
      end
      tick();
      n_checks++;
      if (obs !== expected()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h want %h", i, obs, expected());
      end
    end
  endtask
  initial begin
    test_reset();
    test_scan_order();
    test_blanking();
    test_tearing();
    test_enable();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
